// File: rtl/argmax_stage.sv
// Argmax over one captured vector of N_OUT signed 16-bit activations.
// Each rising edge of in_done snapshots y; one element is compared per cycle and the result is held until accepted.
module argmax_stage #(
  parameter int N_OUT = 4,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_done,
  input  logic [N_OUT*16-1:0]  y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     idx,
  output logic signed [15:0]   max_val,
  output logic                 busy,
  output logic                 dropped,
  output logic [1:0]           state_dbg
);

  // Handshake: the result is transferred on a rising clk edge where out_valid and
  // out_ready are both high; out_valid, idx and max_val do not change until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OUT - 1);

  state_t                 state, state_nx;
  logic                   done_q;
  logic                   start;
  logic [IDX_W-1:0]       cnt;
  logic [IDX_W-1:0]       best_idx;
  logic signed [15:0]     best_val;
  logic signed [15:0]     vec_q [N_OUT];

  assign start = in_done & ~done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (N_OUT == 1) ? HOLD : SCAN;
      SCAN:    if (cnt == LAST) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      dropped  <= 1'b0;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= '0;
      for (int k = 0; k < N_OUT; k++) vec_q[k] <= '0;
    end else begin
      done_q  <= in_done;
      // Any start seen outside IDLE, including the handshake edge, is discarded.
      dropped <= start && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N_OUT; k++) vec_q[k] <= y[16*k +: 16];
            best_val <= y[15:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
          end
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (vec_q[cnt] > best_val) begin
            best_val <= vec_q[cnt];
            best_idx <= cnt;
          end
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign idx       = best_idx;
  assign max_val   = best_val;
  assign state_dbg = state;

endmodule

// File: tb/tb_argmax_stage.sv
// Directed bench for argmax_stage (N_OUT = 4): latency, signed compare, ties,
// capture isolation, stalls, dropped starts and reset aborts.
module tb_argmax_stage;

  localparam int N_OUT = 4;
  localparam int IDX_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_done;
  logic [N_OUT*16-1:0] y;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    idx;
  logic signed [15:0]  max_val;
  logic                busy;
  logic                dropped;
  logic [1:0]          state_dbg;

  int n_vec = 0;
  int n_err = 0;

  argmax_stage #(.N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .in_done(in_done), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .idx(idx),
    .max_val(max_val), .busy(busy), .dropped(dropped), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; the edge after start_vec returns is E0 already past.
  task automatic start_vec(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    @(negedge clk);
    in_done = 1'b0;
    y = {e3, e2, e1, e0};
    @(negedge clk);
    in_done = 1'b1;
    @(negedge clk);
  endtask

  // lat = number of cycles after E0 at which out_valid was first seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_done = 1'b0; out_ready = 1'b0; y = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_valid, busy, dropped} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {out_valid, busy, dropped});
    end
    n_vec++;
    if (idx !== 2'd0 || max_val !== 16'sd0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_data: got idx=%0d max=%0d st=%0d expected 0 0 0", idx, max_val, state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    start_vec(16'd3, 16'hFFF9, 16'd12, 16'd5);
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_scan: got busy=%b valid=%b expected 1 0", busy, out_valid);
    end
    wait_valid(lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++; $display("FAIL basic_latency: got %0d expected 4", lat);
    end
    n_vec++;
    if (idx !== 2'd2 || max_val !== 16'sd12) begin
      n_err++; $display("FAIL basic_result: got idx=%0d max=%0d expected 2 12", idx, max_val);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    n_vec++;
    if (idx !== 2'd2 || max_val !== 16'sd12) begin
      n_err++; $display("FAIL basic_hold_idle: got idx=%0d max=%0d expected 2 12", idx, max_val);
    end
    in_done = 1'b0;
  endtask

  task automatic test_tie_signed;
    int lat;
    out_ready = 1'b1;
    start_vec(16'hFFFB, 16'hFFFE, 16'hFFFE, 16'hFFF7);
    wait_valid(lat);
    n_vec++;
    if (idx !== 2'd1 || max_val !== -16'sd2) begin
      n_err++; $display("FAIL tie_signed: got idx=%0d max=%0d expected 1 -2", idx, max_val);
    end
    @(negedge clk);
    in_done = 1'b0;
  endtask

  task automatic test_capture;
    int lat;
    out_ready = 1'b1;
    start_vec(16'h7FFF, 16'h8000, 16'h0000, 16'h0001);
    y = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
    wait_valid(lat);
    n_vec++;
    if (idx !== 2'd0 || max_val !== 16'sh7FFF) begin
      n_err++; $display("FAIL capture_extreme: got idx=%0d max=%h expected 0 7fff", idx, max_val);
    end
    @(negedge clk);
    start_vec(16'd1, 16'd2, 16'd3, 16'd4);
    y = {16'd0, 16'd3, 16'd2, 16'd1};
    wait_valid(lat);
    n_vec++;
    if (idx !== 2'd3 || max_val !== 16'sd4) begin
      n_err++; $display("FAIL capture_isolate: got idx=%0d max=%0d expected 3 4", idx, max_val);
    end
    @(negedge clk);
    in_done = 1'b0;
  endtask

  task automatic test_hold_stall;
    int lat;
    out_ready = 1'b0;
    start_vec(16'd10, 16'd20, 16'd30, 16'd5);
    in_done = 1'b0;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || idx !== 2'd2 || max_val !== 16'sd30) begin
        n_err++; $display("FAIL hold_stall_%0d: got v=%b idx=%0d max=%0d expected 1 2 30", i, out_valid, idx, max_val);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_drop_in_scan;
    int drops = 0;
    out_ready = 1'b1;
    start_vec(16'd1, 16'd9, 16'd2, 16'd3);
    in_done = 1'b0;
    @(negedge clk);
    in_done = 1'b1;
    y = {16'd100, 16'd100, 16'd100, 16'd100};
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(negedge clk);
      if (dropped) drops++;
    end
    n_vec++;
    if (idx !== 2'd1 || max_val !== 16'sd9) begin
      n_err++; $display("FAIL drop_scan_result: got idx=%0d max=%0d expected 1 9", idx, max_val);
    end
    @(negedge clk);
    if (dropped) drops++;
    n_vec++;
    if (drops !== 1) begin
      n_err++; $display("FAIL drop_scan_count: got %0d expected 1", drops);
    end
    in_done = 1'b0;
  endtask

  task automatic test_drop_on_handshake;
    int lat;
    out_ready = 1'b0;
    start_vec(16'd4, 16'd3, 16'd2, 16'd1);
    in_done = 1'b0;
    wait_valid(lat);
    n_vec++;
    if (idx !== 2'd0 || max_val !== 16'sd4) begin
      n_err++; $display("FAIL hs_result: got idx=%0d max=%0d expected 0 4", idx, max_val);
    end
    in_done = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, busy, dropped} !== 3'b001) begin
      n_err++; $display("FAIL hs_drop: got v/b/d=%b expected 001", {out_valid, busy, dropped});
    end
    // in_done stays high: no further capture may occur.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL held_done_%0d: got busy=%b expected 0", i, busy);
      end
    end
    in_done = 1'b0;
  endtask

  task automatic test_rst_mid_scan;
    int lat;
    bit seen = 1'b0;
    out_ready = 1'b1;
    start_vec(16'd1, 16'd2, 16'd3, 16'd4);
    in_done = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, out_valid} !== 2'b00 || idx !== 2'd0 || max_val !== 16'sd0) begin
      n_err++; $display("FAIL rst_abort: got b=%b v=%b idx=%0d max=%0d expected 0 0 0 0", busy, out_valid, idx, max_val);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL rst_no_valid: got %b expected 0", seen);
    end
    start_vec(16'hFFFF, 16'd7, 16'd7, 16'd6);
    wait_valid(lat);
    n_vec++;
    if (lat !== 4 || idx !== 2'd1 || max_val !== 16'sd7) begin
      n_err++; $display("FAIL rst_restart: got lat=%0d idx=%0d max=%0d expected 4 1 7", lat, idx, max_val);
    end
    @(negedge clk);
    in_done = 1'b0;
  endtask

  task automatic test_rst_done_high;
    int lat;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    in_done = 1'b1;
    y = {16'd2, 16'd8, 16'd1, 16'd0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL rst_done_high_start: got busy=%b expected 1", busy);
    end
    wait_valid(lat);
    n_vec++;
    if (lat !== 4 || idx !== 2'd2 || max_val !== 16'sd8) begin
      n_err++; $display("FAIL rst_done_high_result: got lat=%0d idx=%0d max=%0d expected 4 2 8", lat, idx, max_val);
    end
    @(negedge clk);
    in_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tie_signed();
    test_capture();
    test_hold_stall();
    test_drop_in_scan();
    test_drop_on_handshake();
    test_rst_mid_scan();
    test_rst_done_high();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
